// File: rtl/ysyx_2022040010_mul_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply controller and its multiplier.
package ysyx_2022040010_mul_ctrl_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  localparam logic [2:0] SEL_W  = 3'b001;
  localparam logic [2:0] SEL_HI = 3'b010;
  localparam logic [2:0] SEL_LO = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [2:0] sel_for(input logic [1:0] op, input logic w);
    if (w)
      return SEL_W;
    else if (op == OP_MUL)
      return SEL_LO;
    else
      return SEL_HI;
  endfunction

  function automatic logic a_signed(input logic [1:0] op, input logic w);
    return w | (op != OP_MULHU);
  endfunction

  function automatic logic b_signed(input logic [1:0] op, input logic w);
    return w | (op == OP_MUL) | (op == OP_MULH);
  endfunction

endpackage

// File: rtl/ysyx_2022040010_mul_ctrl_if.sv
// Request/response bundle between the EX stage and the multiply controller.
interface ysyx_2022040010_mul_ctrl_if #(
  parameter int TAGW = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic            in_w;
  logic [63:0]     in_a;
  logic [63:0]     in_b;
  logic [TAGW-1:0] in_tag;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_data;
  logic [TAGW-1:0] out_tag;
  logic            busy;

  modport master (
    output in_valid, in_op, in_w, in_a, in_b, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag, busy
  );

  modport slave (
    input  in_valid, in_op, in_w, in_a, in_b, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/ysyx_2022040010_mul_ctrl_mul.sv
// Combinational 64x64 radix-4 Booth multiplier with carry-save reduction;
// the path is timed as a multicycle path by its controller.
module ysyx_2022040010_mul
  import ysyx_2022040010_mul_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic [63:0] mul_ina,
  input  logic [63:0] mul_inb,
  input  logic        mul_ina_s,
  input  logic        mul_inb_s,
  input  logic        mul_32,
  input  logic [2:0]  sel_mul_hilo,
  output logic [63:0] mul_result,
  output logic        mul_over
);

  logic [65:0]  a_ext;
  logic [65:0]  b_ext;
  logic [66:0]  b_pad;
  logic [127:0] a_w;
  logic [127:0] pp;
  logic [127:0] s_acc;
  logic [127:0] c_acc;
  logic [127:0] s_nxt;
  logic [127:0] prod;
  logic [2:0]   trip;

  logic [63:0]  ina_q;
  logic [63:0]  inb_q;
  logic         act_q;

  always_comb begin
    if (mul_32) begin
      a_ext = {{34{mul_ina[31]}}, mul_ina[31:0]};
      b_ext = {{34{mul_inb[31]}}, mul_inb[31:0]};
    end else begin
      a_ext = {{2{mul_ina_s & mul_ina[63]}}, mul_ina};
      b_ext = {{2{mul_inb_s & mul_inb[63]}}, mul_inb};
    end
  end

  // The product is formed modulo 2^128, which is exact for every bit we select.
  always_comb begin
    b_pad = {b_ext, 1'b0};
    a_w   = {{62{a_ext[65]}}, a_ext};
    s_acc = '0;
    c_acc = '0;
    s_nxt = '0;
    pp    = '0;
    trip  = '0;
    for (int unsigned i = 0; i < 33; i++) begin
      trip = b_pad[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = a_w;
        3'b011:         pp = a_w << 1;
        3'b100:         pp = -(a_w << 1);
        3'b101, 3'b110: pp = -a_w;
        default:        pp = '0;
      endcase
      pp    = pp << (2*i);
      s_nxt = s_acc ^ c_acc ^ pp;
      c_acc = ((s_acc & c_acc) | (s_acc & pp) | (c_acc & pp)) << 1;
      s_acc = s_nxt;
    end
    prod = s_acc + c_acc;
  end

  always_comb begin
    case (sel_mul_hilo)
      SEL_W:   mul_result = {{32{prod[31]}}, prod[31:0]};
      SEL_HI:  mul_result = prod[127:64];
      SEL_LO:  mul_result = prod[63:0];
      default: mul_result = '0;
    endcase
    mul_over = |sel_mul_hilo;
  end

  // Operands must not move while a selection is active across consecutive cycles.
  always_ff @(posedge clk) begin
    act_q <= |sel_mul_hilo;
    ina_q <= mul_ina;
    inb_q <= mul_inb;
    if (act_q && (|sel_mul_hilo))
      assert ((ina_q == mul_ina) && (inb_q == mul_inb));
  end

endmodule

// File: rtl/ysyx_2022040010_mul_ctrl.sv
// Sequences one RV64M multiply at a time through the multicycle multiplier,
// with flush and output backpressure.
module ysyx_2022040010_mul_ctrl
  import ysyx_2022040010_mul_ctrl_pkg::*;
#(
  parameter int LAT  = 2,
  parameter int TAGW = 5
) (
  input logic                      clk,
  input logic                      ret,
  ysyx_2022040010_mul_ctrl_if.slave bus
);

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      cnt_q;
  logic [63:0]     a_q;
  logic [63:0]     b_q;
  logic [1:0]      op_q;
  logic            w_q;
  logic [TAGW-1:0] tag_q;
  logic [63:0]     data_q;
  logic [TAGW-1:0] otag_q;

  logic            in_ready_c;
  logic            busy_c;
  logic            out_valid_c;
  logic [2:0]      sel_c;
  logic            accept;
  logic            capture;
  logic [63:0]     mul_result;
  logic            mul_over;

  always_ff @(posedge clk) begin
    if (ret)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = ST_BUSY;
        ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
        ST_DONE: if (bus.out_ready) state_d = accept ? ST_BUSY : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_c  = ((state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready)) & ~bus.flush;
    busy_c      = (state_q != ST_IDLE);
    out_valid_c = (state_q == ST_DONE);
    sel_c       = '0;
    if (state_q == ST_BUSY)
      sel_c = sel_for(op_q, w_q);
  end

  assign accept  = bus.in_valid & in_ready_c;
  assign capture = (state_q == ST_BUSY) & (cnt_q == '0) & ~bus.flush;

  // Operand registers load only on accept, which never happens in BUSY.
  always_ff @(posedge clk) begin
    if (ret) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      w_q    <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
      otag_q <= '0;
    end else begin
      if (accept) begin
        a_q   <= bus.in_a;
        b_q   <= bus.in_b;
        op_q  <= bus.in_op;
        w_q   <= bus.in_w;
        tag_q <= bus.in_tag;
        cnt_q <= 4'(LAT - 1);
      end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        data_q <= mul_result;
        otag_q <= tag_q;
        assert (mul_over);
      end
    end
  end

  ysyx_2022040010_mul u_mul (
    .clk          (clk),
    .mul_ina      (a_q),
    .mul_inb      (b_q),
    .mul_ina_s    (a_signed(op_q, w_q)),
    .mul_inb_s    (b_signed(op_q, w_q)),
    .mul_32       (w_q),
    .sel_mul_hilo (sel_c),
    .mul_result   (mul_result),
    .mul_over     (mul_over)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = data_q;
  assign bus.out_tag   = otag_q;

endmodule

// File: tb/tb_ysyx_2022040010_mul_ctrl.sv
// Directed bench for the multiply controller with hand-computed results.
module tb_ysyx_2022040010_mul_ctrl;
  import ysyx_2022040010_mul_ctrl_pkg::*;

  localparam int LAT  = 2;
  localparam int TAGW = 5;

  logic clk;
  logic ret;
  int   total;
  int   bad;
  logic [63:0] last_data;

  ysyx_2022040010_mul_ctrl_if #(.TAGW(TAGW)) bus ();

  ysyx_2022040010_mul_ctrl #(.LAT(LAT), .TAGW(TAGW)) dut (
    .clk (clk),
    .ret (ret),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input string name, output int k);
    k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 20) begin
      step();
      k++;
      @(negedge clk);
    end
    total++;
    if (k !== LAT) begin
      bad++;
      $display("FAIL %s latency: got %0d edges want %0d", name, k, LAT);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [TAGW-1:0] tag, input logic [63:0] exp);
    int k;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_w = w;
    bus.in_a = a; bus.in_b = b; bus.in_tag = tag;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL %s in_ready: got %b want 1", name, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    wait_result(name, k);
    total++;
    if (bus.out_data !== exp) begin
      bad++; $display("FAIL %s data: got %h want %h", name, bus.out_data, exp);
    end
    total++;
    if (bus.out_tag !== tag) begin
      bad++; $display("FAIL %s tag: got %h want %h", name, bus.out_tag, tag);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s drain: got valid=%b busy=%b ready=%b want 0 0 1",
               name, bus.out_valid, bus.busy, bus.in_ready);
    end
    last_data = exp;
    step();
  endtask

  task automatic test_reset();
    ret = 1'b1;
    step();
    step();
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
    total++;
    if (bus.out_data !== 64'd0 || bus.out_tag !== '0) begin
      bad++; $display("FAIL reset_data: got %h/%h want 0/0", bus.out_data, bus.out_tag);
    end
    step();
    ret = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", bus.in_ready);
    end
    step();
  endtask

  task automatic test_ops();
    run_op("mul_neg", OP_MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'h0A, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("mulhu", OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'h11, 64'h1);
    run_op("mulh", OP_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'h02, 64'h0);
    run_op("mulhsu", OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'h15, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mulw", OP_MULHU, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'h1E, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhu_max", OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           5'h07, 64'hFFFF_FFFF_FFFF_FFFE);
  endtask

  task automatic test_backpressure();
    int k;
    bus.in_valid = 1'b1; bus.in_op = OP_MUL; bus.in_w = 1'b0;
    bus.in_a = 64'd6; bus.in_b = 64'd7; bus.in_tag = 5'h03;
    @(negedge clk);
    step();
    bus.in_valid = 1'b0;
    wait_result("bp_first", k);
    bus.in_valid = 1'b1; bus.in_op = OP_MULHU;
    bus.in_a = 64'h8000_0000_0000_0000; bus.in_b = 64'd4; bus.in_tag = 5'h1F;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (bus.out_data !== 64'd42 || bus.out_tag !== 5'h03) begin
        bad++; $display("FAIL bp_hold: got %h/%h want 2a/03", bus.out_data, bus.out_tag);
      end
      total++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_flags: got ready=%b busy=%b valid=%b want 0 1 1",
                 bus.in_ready, bus.busy, bus.out_valid);
      end
      step();
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_overlap_ready: got %b want 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    wait_result("bp_second", k);
    total++;
    if (bus.out_data !== 64'd2 || bus.out_tag !== 5'h1F) begin
      bad++; $display("FAIL bp_second_data: got %h/%h want 2/1f", bus.out_data, bus.out_tag);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    last_data = 64'd2;
    step();
  endtask

  task automatic test_flush(input string name, input int wait_edges);
    bus.in_valid = 1'b1; bus.in_op = OP_MUL; bus.in_w = 1'b0;
    bus.in_a = 64'd100; bus.in_b = 64'd5; bus.in_tag = 5'h09;
    @(negedge clk);
    step();
    bus.in_valid = 1'b0;
    repeat (wait_edges) step();
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL %s during: got busy=%b ready=%b want 1 0", name, bus.busy, bus.in_ready);
    end
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== last_data) begin
        bad++;
        $display("FAIL %s after: got valid=%b busy=%b data=%h want 0 0 %h",
                 name, bus.out_valid, bus.busy, bus.out_data, last_data);
      end
      step();
    end
    run_op({name, "_next"}, OP_MUL, 1'b0, 64'd100, 64'd5, 5'h09, 64'd500);
  endtask

  task automatic test_ret_mid_busy();
    bus.in_valid = 1'b1; bus.in_op = OP_MUL; bus.in_w = 1'b0;
    bus.in_a = 64'd11; bus.in_b = 64'd13; bus.in_tag = 5'h0C;
    @(negedge clk);
    step();
    bus.in_valid = 1'b0;
    ret = 1'b1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL ret_pre: got busy=%b want 1", bus.busy);
    end
    step();
    ret = 1'b0;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ret_flags: got valid=%b busy=%b ready=%b want 0 0 1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
    total++;
    if (bus.out_data !== 64'd0 || bus.out_tag !== '0) begin
      bad++; $display("FAIL ret_data: got %h/%h want 0/0", bus.out_data, bus.out_tag);
    end
    step();
    last_data = 64'd0;
    run_op("after_ret", OP_MUL, 1'b0, 64'd11, 64'd13, 5'h0C, 64'd143);
  endtask

  initial begin
    total = 0;
    bad = 0;
    last_data = '0;
    ret = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_w = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_ops();
    test_backpressure();
    test_flush("flush_first", 0);
    test_flush("flush_capture", LAT - 1);
    test_ret_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_2022040010_mul_ctrl.md
# ysyx_2022040010_mul_ctrl

Sequencing controller for the 64-bit Booth/Wallace multiplier `ysyx_2022040010_mul` in the EX stage. It accepts one RV64M multiply op at a time through a valid/ready handshake and registers the operands. It holds them on the combinational multiplier for a fixed multicycle window, then captures the selected result into an output register. It also handles pipeline flush and output backpressure.

## Interface
Parameters:
- `LAT`, 2: cycles the operands stay applied before capture; legal range 1..15. The multiplier path is constrained as a LAT-cycle multicycle path.
- `TAGW`, 5: width of the pass-through tag (destination register index).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `ret`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  op request.
- `in_ready`  out  1  controller can accept this cycle.
- `in_op`  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `in_w`  in  1  word op (MULW); forces low-32 sign-extended result; `in_op` ignored.
- `in_a`, `in_b`  in  64  rs1, rs2.
- `in_tag`  in  TAGW  passed through to `out_tag`.
- `flush`  in  1  kill any in-flight or pending op.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  64  result.
- `out_tag`  out  TAGW  tag of the result.
- `busy`  out  1  state != IDLE; EX stall source.

## Operation
- States: IDLE, BUSY, DONE. Reset values: state IDLE, counter 0, `out_valid` 0, `out_data` 0, `out_tag` 0, operand/op registers 0.
- Outputs: `in_ready` = (IDLE | (DONE & out_ready)) & ~flush. `busy` = state != IDLE.
- Accept on `in_valid & in_ready`:
  - latch `a`, `b`, op, w and tag;
  - set counter = LAT-1;
  - go to BUSY.
- Signedness drive to the multiplier, from the latched op:
  - MUL and MULH: `mul_ina_s`=1, `mul_inb_s`=1.
  - MULHSU: 1, 0.
  - MULHU: 0, 0.
  - W op: 1, 1.
  - `mul_32` = w.
- `sel_mul_hilo` is one-hot and non-zero only in BUSY:
  - w → 001;
  - MULH/MULHSU/MULHU → 010;
  - MUL → 100.
  - It is 000 in IDLE and DONE, so the multiplier's `mul_over` is low outside BUSY.
- BUSY:
  - If counter != 0, decrement.
  - If counter == 0, capture `mul_result` into `out_data` and the tag into `out_tag`, then go to DONE. Assert a sim-only check that `mul_over`=1 at this point.
- DONE: `out_valid`=1.
  - On `out_ready` with no new accept, go to IDLE.
  - On `out_ready` with a simultaneous accept, go directly to BUSY. `out_valid` drops the same edge.
  - Without `out_ready`, hold `out_data`/`out_tag` stable.
- `flush` has top priority in every state. Next state is IDLE, `out_valid`=0, and no accept that cycle. `out_data` is left unchanged.
- `ret` has priority over `flush`.

## Timing
- Accept at the edge ending cycle T. BUSY spans cycles T+1 .. T+LAT. Capture at the edge ending T+LAT. `out_valid`=1 from cycle T+LAT+1.
- Issue-to-result latency is LAT+1 cycles. With LAT=2, `out_valid` rises in cycle 3.
- Throughput with `out_ready` held high is one op per LAT+1 cycles, because the DONE-cycle accept overlaps.
- Operand registers must not change during BUSY. They are the only multiplier inputs, which is what makes the multicycle constraint valid.
- `out_data` changes only on the capture edge.
- Flush in the capture cycle wins: no capture, and `out_valid` stays 0.
- `ret` mid-BUSY returns to IDLE next edge with all outputs at reset values.

## Structure
- Shared package holds:
  - the op encoding constants (OP_MUL=2'b00, OP_MULH=2'b01, OP_MULHSU=2'b10, OP_MULHU=2'b11);
  - the SEL_W/SEL_HI/SEL_LO one-hot constants;
  - the state encoding.
- One sub-module: an instance of `ysyx_2022040010_mul`, with `clk` connected. Nothing else is instantiated.
- Counter width is 4 bits.

## Test plan
- MUL a=3, b=0xFFFF_FFFF_FFFF_FFFB (−5), LAT=2 → `out_valid` in cycle 3, `out_data`=0xFFFF_FFFF_FFFF_FFF1, tag echoed.
- MULHU a=0xFFFF_FFFF_FFFF_FFFF, b=2 → 0x1.
- MULH a=b=−1 → 0x0.
- MULHSU a=−1, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
- MULW a=0x7FFF_FFFF, b=2 → 0xFFFF_FFFF_FFFF_FFFE.
- Backpressure: hold `out_ready`=0 for 5 cycles after DONE → `out_data` stable, `in_ready`=0, `busy`=1. Then raise `out_ready` together with a new valid op → accepted that cycle, and the second result arrives LAT+1 cycles later.
- Flush in the first BUSY cycle, and separately in the capture cycle → IDLE next cycle, `out_valid` never rises, next op completes normally.
- `ret` asserted mid-BUSY for 1 cycle → all outputs at reset values, `in_ready`=1 the cycle after release.
